mpi_dma_arbiter: RTL and testbench
==================================

MPI_DMA_ARBITER -- requirements
Module: mpi_dma_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 2, number of DMA requesters (2..4).
REQ-002 SHALL have parameter GNT_TO, default 16, max cycles from device grant to device SACK.
REQ-003 SHALL have parameter BUS_TO, default 64, max cycles a DIN/DOUT strobe waits for RPLY.
REQ-004 SHALL have port clk  in  1  system clock; all logic on rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port dev_dmr  in  NREQ  per-device DMA request.
REQ-007 SHALL have port dev_sack  in  NREQ  per-device bus-acquired acknowledge.
REQ-008 SHALL have port dev_dmgo  out  NREQ  per-device grant, one-hot or zero.
REQ-009 SHALL have port cpu_dmr  out  1  combined request to the CPU.
REQ-010 SHALL have port cpu_dmgo  in  1  grant from the CPU.
REQ-011 SHALL have port cpu_sack  out  1  forwarded SACK to the CPU.
REQ-012 SHALL have ports sync, din, dout, rply  in  1 each  bus strobes, pre-synchronised, active-high.
REQ-013 SHALL have port owner  out  max(1,clog2(NREQ))  index of the current or last owner.
REQ-014 SHALL have port busy  out  1  high in every state except IDLE.
REQ-015 SHALL have port bus_err  out  1  one-cycle pulse on bus timeout.

Function
REQ-016 SHALL implement a five-state FSM: IDLE, REQ, GRANT, OWN, REL.
REQ-017 IDLE: when any dev_dmr is high, SHALL latch the winner and go to REQ next cycle.
REQ-018 Winner selection SHALL be round-robin: the search starts at index owner+1 (mod NREQ), so the last owner has lowest priority.
REQ-019 REQ: cpu_dmr SHALL be high; on cpu_dmgo high, go to GRANT.
REQ-020 REQ: if the winner's dev_dmr drops before cpu_dmgo, SHALL return to IDLE with no grant issued.
REQ-021 GRANT: dev_dmgo[winner] SHALL be high and cpu_dmr held high.
REQ-022 GRANT: on dev_sack[winner] high, go to OWN.
REQ-023 GRANT: if GNT_TO cycles pass without SACK, SHALL drop the grant and go to IDLE; owner SHALL still update.
REQ-024 OWN: cpu_sack SHALL follow dev_sack[winner]; dev_dmgo and cpu_dmr SHALL be low.
REQ-025 OWN: on dev_sack[winner] low, go to REL.
REQ-026 REL: all outputs except owner and busy SHALL be low for exactly one cycle, then go to IDLE; new requests are evaluated only from IDLE.
REQ-027 dev_sack from a non-winner SHALL be ignored in every state.
REQ-028 Output latency: every output SHALL be registered and change one cycle after the state change.
REQ-029 Watchdog: a counter SHALL increment each cycle sync && (din || dout) && !rply, and clear otherwise.
REQ-030 When the watchdog reaches BUS_TO-1, bus_err SHALL pulse for one cycle and the counter SHALL clear.
REQ-031 The watchdog SHALL run in every FSM state, for CPU and DMA masters alike, and SHALL saturate rather than wrap.
REQ-032 If bus_err fires while the FSM is in OWN, the FSM SHALL go to REL and force cpu_sack low.

Reset
REQ-033 rst SHALL set the FSM to IDLE and drive dev_dmgo=0, cpu_dmr=0, cpu_sack=0, busy=0, bus_err=0, owner=NREQ-1, and clear both counters.
REQ-034 rst asserted mid-grant or mid-ownership SHALL take effect at the next edge, with no residual pulse on any output.

Structure
REQ-035 A shared package SHALL hold the FSM state enum and the default GNT_TO and BUS_TO values.
REQ-036 The round-robin priority pick SHALL be a sub-module rr_pick (request vector plus last index in, winner index plus valid out, combinational).

Verification
REQ-037 Single request: dev_dmr=01, cpu_dmgo asserted 3 cycles after cpu_dmr, dev_sack[0] 2 cycles after grant, held 5 cycles -> dev_dmgo=01 during GRANT, cpu_sack high for 5 cycles, one REL cycle, owner=0.
REQ-038 Fairness: dev_dmr=11 held continuously, each owner holds SACK 4 cycles -> grants alternate 0,1,0,1 starting with 0 after reset.
REQ-039 Grant timeout: dev_dmr=10, cpu_dmgo given, no SACK -> dev_dmgo=10 for exactly 16 cycles, then IDLE, owner=1.
REQ-040 Withdrawn request: dev_dmr=01 dropped while in REQ, before cpu_dmgo -> return to IDLE, dev_dmgo never asserted.
REQ-041 Bus timeout: sync=1, din=1, rply=0 for 70 cycles -> a single bus_err pulse on cycle 64; if in OWN, REL follows.
REQ-042 Reset during OWN: rst for 1 cycle -> next cycle all outputs at reset values, owner=1 (NREQ=2).

Source files
------------

// File: rtl/mpi_dma_arbiter_pkg.sv
// Shared types and defaults for the DMA bus arbiter: FSM encoding, timeout
// defaults and the owner-index width helper.
package mpi_dma_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_GRANT,
    ST_OWN,
    ST_REL
  } state_t;

  localparam int DEF_GNT_TO = 16;
  localparam int DEF_BUS_TO = 64;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: searches from i_last+1 (mod N) upward,
// so the previous winner gets the lowest priority.
module rr_pick #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_last,
  output logic [W-1:0] o_idx,
  output logic         o_vld
);

  function automatic logic [W-1:0] nth_after(input logic [W-1:0] last, input int k);
    return W'((int'(last) + k) % N);
  endfunction

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment, otherwise synthesis infers a latch.
  always_comb begin
    o_idx = '0;
    o_vld = 1'b0;
    for (int k = 1; k <= N; k++) begin
      if (!o_vld && i_req[nth_after(i_last, k)]) begin
        o_idx = nth_after(i_last, k);
        o_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mpi_dma_arbiter.sv
// DMA bus arbiter: forwards one device request at a time to the CPU, hands
// the grant back to the round-robin winner and watches bus strobes for RPLY.
module mpi_dma_arbiter
  import mpi_dma_arbiter_pkg::*;
#(
  parameter  int NREQ   = 2,
  parameter  int GNT_TO = DEF_GNT_TO,
  parameter  int BUS_TO = DEF_BUS_TO,
  localparam int OW     = idx_w(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] dev_dmr,
  input  logic [NREQ-1:0] dev_sack,
  output logic [NREQ-1:0] dev_dmgo,
  output logic            cpu_dmr,
  input  logic            cpu_dmgo,
  output logic            cpu_sack,
  input  logic            sync,
  input  logic            din,
  input  logic            dout,
  input  logic            rply,
  output logic [OW-1:0]   owner,
  output logic            busy,
  output logic            bus_err
);

  localparam int GW = $clog2(GNT_TO + 1);
  localparam int BW = $clog2(BUS_TO + 1);

  state_t          r_state;
  state_t          w_next;
  logic [OW-1:0]   r_win;
  logic [OW-1:0]   r_owner;
  logic [GW-1:0]   r_gnt_cnt;
  logic [BW-1:0]   r_wd_cnt;
  logic [NREQ-1:0] r_dev_dmgo;
  logic            r_cpu_dmr;
  logic            r_cpu_sack;
  logic            r_busy;
  logic            r_bus_err;

  logic [OW-1:0]   w_pick_idx;
  logic            w_pick_vld;
  logic            w_wd_cond;
  logic            w_wd_fire;
  logic            w_gnt_expired;
  logic [NREQ-1:0] w_dev_dmgo;
  logic            w_cpu_dmr;
  logic            w_cpu_sack;

  rr_pick #(
    .N (NREQ),
    .W (OW)
  ) u_rr_pick (
    .i_req  (dev_dmr),
    .i_last (r_owner),
    .o_idx  (w_pick_idx),
    .o_vld  (w_pick_vld)
  );

  // Watchdog covers any master: a strobe left unanswered by RPLY.
  assign w_wd_cond     = sync && (din || dout) && !rply;
  assign w_wd_fire     = w_wd_cond && (r_wd_cnt == BW'(BUS_TO - 1));
  assign w_gnt_expired = (r_gnt_cnt == GW'(GNT_TO - 1));

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:  if (w_pick_vld) w_next = ST_REQ;
      ST_REQ: begin
        if (!dev_dmr[r_win])  w_next = ST_IDLE;
        else if (cpu_dmgo)    w_next = ST_GRANT;
      end
      ST_GRANT: begin
        if (dev_sack[r_win])  w_next = ST_OWN;
        else if (w_gnt_expired) w_next = ST_IDLE;
      end
      ST_OWN:   if (w_wd_fire || !dev_sack[r_win]) w_next = ST_REL;
      ST_REL:   w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered alongside it, so
  // they are glitch-free and line up with the state register.
  always_comb begin
    w_dev_dmgo = '0;
    if (w_next == ST_GRANT) w_dev_dmgo[r_win] = 1'b1;
    w_cpu_dmr  = (w_next == ST_REQ) || (w_next == ST_GRANT);
    w_cpu_sack = (w_next == ST_OWN);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_win      <= '0;
      r_owner    <= OW'(NREQ - 1);
      r_dev_dmgo <= '0;
      r_cpu_dmr  <= 1'b0;
      r_cpu_sack <= 1'b0;
      r_busy     <= 1'b0;
      r_bus_err  <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_dev_dmgo <= w_dev_dmgo;
      r_cpu_dmr  <= w_cpu_dmr;
      r_cpu_sack <= w_cpu_sack;
      r_busy     <= (w_next != ST_IDLE);
      r_bus_err  <= w_wd_fire;
      if (r_state == ST_IDLE && w_pick_vld) r_win <= w_pick_idx;
      if (r_state == ST_REQ && w_next == ST_GRANT) r_owner <= r_win;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_gnt_cnt <= '0;
    end else if (r_state == ST_GRANT && w_next == ST_GRANT) begin
      r_gnt_cnt <= r_gnt_cnt + 1'b1;
    end else begin
      r_gnt_cnt <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wd_cnt <= '0;
    end else if (!w_wd_cond || w_wd_fire) begin
      r_wd_cnt <= '0;
    end else if (r_wd_cnt != '1) begin
      r_wd_cnt <= r_wd_cnt + 1'b1;
    end
  end

  assign dev_dmgo = r_dev_dmgo;
  assign cpu_dmr  = r_cpu_dmr;
  assign cpu_sack = r_cpu_sack;
  assign owner    = r_owner;
  assign busy     = r_busy;
  assign bus_err  = r_bus_err;

endmodule

// File: tb/tb_mpi_dma_arbiter.sv
// Directed bench for mpi_dma_arbiter (NREQ=2): single transfer, fairness,
// grant timeout, withdrawn request, bus watchdog and reset during ownership.
module tb_mpi_dma_arbiter;

  localparam int NREQ = 2;

  logic            clk;
  logic            rst;
  logic [NREQ-1:0] dev_dmr;
  logic [NREQ-1:0] dev_sack;
  logic [NREQ-1:0] dev_dmgo;
  logic            cpu_dmr;
  logic            cpu_dmgo;
  logic            cpu_sack;
  logic            sync;
  logic            din;
  logic            dout;
  logic            rply;
  logic            owner;
  logic            busy;
  logic            bus_err;

  int n_checks = 0;
  int n_errors = 0;

  mpi_dma_arbiter #(
    .NREQ   (NREQ),
    .GNT_TO (16),
    .BUS_TO (64)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .dev_dmr  (dev_dmr),
    .dev_sack (dev_sack),
    .dev_dmgo (dev_dmgo),
    .cpu_dmr  (cpu_dmr),
    .cpu_dmgo (cpu_dmgo),
    .cpu_sack (cpu_sack),
    .sync     (sync),
    .din      (din),
    .dout     (dout),
    .rply     (rply),
    .owner    (owner),
    .busy     (busy),
    .bus_err  (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_dmgo(input string tag);
    int n;
    n = 0;
    while (dev_dmgo == '0 && n < 30) begin
      tick();
      n++;
    end
    check(tag, 32'(dev_dmgo != '0), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int n;
    int pulses;
    int pos;
    logic seen;

    rst = 1'b1; dev_dmr = '0; dev_sack = '0; cpu_dmgo = 1'b0;
    sync = 1'b0; din = 1'b0; dout = 1'b0; rply = 1'b0;
    tick();
    tick();

    // Reset values
    check("rst_dmgo",    32'(dev_dmgo), 32'd0);
    check("rst_cpu_dmr", 32'(cpu_dmr),  32'd0);
    check("rst_cpu_sack",32'(cpu_sack), 32'd0);
    check("rst_busy",    32'(busy),     32'd0);
    check("rst_bus_err", 32'(bus_err),  32'd0);
    check("rst_owner",   32'(owner),    32'd1);
    rst = 1'b0;

    // Single request from device 0
    dev_dmr = 2'b01;
    tick();
    check("single_req_cpu_dmr", 32'(cpu_dmr),  32'd1);
    check("single_req_busy",    32'(busy),     32'd1);
    check("single_req_dmgo",    32'(dev_dmgo), 32'd0);
    tick();
    tick();
    tick();
    check("single_req_hold", 32'(cpu_dmr), 32'd1);
    cpu_dmgo = 1'b1;
    tick();
    cpu_dmgo = 1'b0;
    check("single_gnt_dmgo",    32'(dev_dmgo), 32'd1);
    check("single_gnt_cpu_dmr", 32'(cpu_dmr),  32'd1);
    check("single_gnt_owner",   32'(owner),    32'd0);
    tick();
    check("single_gnt_dmgo2", 32'(dev_dmgo), 32'd1);
    dev_sack = 2'b01;
    dev_dmr  = 2'b00;
    n = 0;
    repeat (5) begin
      tick();
      if (cpu_sack) n++;
    end
    check("single_own_sack_cycles", 32'(n), 32'd5);
    check("single_own_dmgo",    32'(dev_dmgo), 32'd0);
    check("single_own_cpu_dmr", 32'(cpu_dmr),  32'd0);
    dev_sack = 2'b00;
    tick();
    check("single_rel_sack", 32'(cpu_sack), 32'd0);
    check("single_rel_busy", 32'(busy),     32'd1);
    tick();
    check("single_idle_busy",  32'(busy),  32'd0);
    check("single_idle_owner", 32'(owner), 32'd0);

    // Fairness: both requesting, grants alternate starting at 0
    do_reset();
    dev_dmr  = 2'b11;
    cpu_dmgo = 1'b1;
    for (int r = 0; r < 4; r++) begin
      wait_dmgo("fair_wait");
      check("fair_gnt",   32'(dev_dmgo), (r % 2 == 0) ? 32'd1 : 32'd2);
      check("fair_owner", 32'(owner),    32'(r % 2));
      dev_sack = dev_dmgo;
      repeat (4) tick();
      dev_sack = 2'b00;
    end
    dev_dmr  = 2'b00;
    cpu_dmgo = 1'b0;
    repeat (3) tick();
    check("fair_end_busy", 32'(busy), 32'd0);

    // Grant timeout for device 1, with a stray SACK from device 0
    dev_dmr  = 2'b10;
    cpu_dmgo = 1'b1;
    dev_sack = 2'b01;
    wait_dmgo("to_wait");
    dev_dmr = 2'b00;
    check("to_gnt_dmgo",  32'(dev_dmgo), 32'd2);
    check("to_gnt_owner", 32'(owner),    32'd1);
    n = 0;
    while (dev_dmgo == 2'b10 && n < 40) begin
      n++;
      tick();
    end
    check("to_gnt_cycles", 32'(n),        32'd16);
    check("to_idle_busy",  32'(busy),     32'd0);
    check("to_idle_dmr",   32'(cpu_dmr),  32'd0);
    check("to_idle_sack",  32'(cpu_sack), 32'd0);
    check("to_idle_owner", 32'(owner),    32'd1);
    dev_sack = 2'b00;
    cpu_dmgo = 1'b0;

    // Withdrawn request while waiting for the CPU
    dev_dmr = 2'b01;
    tick();
    check("wd_req_cpu_dmr", 32'(cpu_dmr), 32'd1);
    dev_dmr = 2'b00;
    tick();
    check("wd_idle_cpu_dmr", 32'(cpu_dmr), 32'd0);
    check("wd_idle_busy",    32'(busy),    32'd0);
    cpu_dmgo = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      tick();
      if (dev_dmgo != '0) seen = 1'b1;
    end
    check("wd_no_grant", 32'(seen),  32'd0);
    check("wd_owner",    32'(owner), 32'd1);

    // Bus timeout while device 0 owns the bus
    dev_dmr = 2'b01;
    wait_dmgo("bto_wait");
    dev_sack = 2'b01;
    dev_dmr  = 2'b00;
    tick();
    check("bto_own_sack", 32'(cpu_sack), 32'd1);
    sync = 1'b1;
    din  = 1'b1;
    pulses = 0;
    pos    = 0;
    for (int i = 1; i <= 70; i++) begin
      tick();
      if (bus_err) begin
        pulses++;
        pos = i;
      end
      if (i == 63) check("bto_sack_before", 32'(cpu_sack), 32'd1);
      if (i == 64) begin
        check("bto_sack_forced", 32'(cpu_sack), 32'd0);
        check("bto_rel_busy",    32'(busy),     32'd1);
      end
      if (i == 65) check("bto_idle_busy", 32'(busy), 32'd0);
    end
    check("bto_pulses", 32'(pulses), 32'd1);
    check("bto_pos",    32'(pos),    32'd64);
    sync     = 1'b0;
    din      = 1'b0;
    dev_sack = 2'b00;
    tick();

    // Reset during ownership by device 1
    dev_dmr = 2'b10;
    wait_dmgo("rown_wait");
    dev_sack = 2'b10;
    dev_dmr  = 2'b00;
    tick();
    check("rown_sack", 32'(cpu_sack), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rown_dmgo",    32'(dev_dmgo), 32'd0);
    check("rown_cpu_dmr", 32'(cpu_dmr),  32'd0);
    check("rown_cpu_sack",32'(cpu_sack), 32'd0);
    check("rown_busy",    32'(busy),     32'd0);
    check("rown_bus_err", 32'(bus_err),  32'd0);
    check("rown_owner",   32'(owner),    32'd1);
    tick();
    check("rown_after_sack", 32'(cpu_sack), 32'd0);
    check("rown_after_busy", 32'(busy),     32'd0);
    dev_sack = 2'b00;
    cpu_dmgo = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
